// File: rtl/signed_mult_seq_if.sv
// Operand/result handshake bundle for signed_mult_seq.
// The master side presents the operands and consumes the product. The slave side is the multiplier.
interface signed_mult_seq_if #(
  parameter int WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;
  logic                 ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy, ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy, ovf
  );
endinterface

// File: rtl/signed_mult_seq.sv
// Multi-cycle signed WIDTH x WIDTH multiplier: sign-magnitude conversion, shift-add, then sign fixup.
// Define SIGNED_MULT_OVF_EN to register a signed-WIDTH overflow flag alongside the product.
module signed_mult_seq #(
  parameter int WIDTH = 16
) (
  input logic            clk,
  input logic            rst,
  signed_mult_seq_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, ABS, MUL, FIX, DONE} state_t;

  state_t               state;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic                 neg;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        count;

  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic [2*WIDTH-1:0]   fixed;

  // op_a/op_b hold the raw operands in ABS and the magnitudes from MUL on.
  // The magnitude is unsigned WIDTH bits, so MIN_INT maps to 2**(WIDTH-1).
  always_comb begin
    abs_a = op_a[WIDTH-1] ? ('0 - op_a) : op_a;
    abs_b = op_b[WIDTH-1] ? ('0 - op_b) : op_b;
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (op_b[0] ? {1'b0, op_a} : '0);
    fixed = neg ? ('0 - acc) : acc;
  end

`ifdef SIGNED_MULT_OVF_EN
  logic [WIDTH:0] top_bits;
  assign top_bits = fixed[2*WIDTH-1:WIDTH-1];
`else
  assign bus.ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.product   <= '0;
      op_a          <= '0;
      op_b          <= '0;
      neg           <= 1'b0;
      acc           <= '0;
      count         <= '0;
`ifdef SIGNED_MULT_OVF_EN
      bus.ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_a         <= bus.a;
            op_b         <= bus.b;
            neg          <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b1;
            state        <= ABS;
          end
        end
        ABS: begin
          op_a  <= abs_a;
          op_b  <= abs_b;
          acc   <= '0;
          count <= CW'(WIDTH - 1);
          state <= MUL;
        end
        MUL: begin
          // The carry lands in the top bit while the low half collects the shifted-out product bits.
          acc  <= {sum, acc[WIDTH-1:1]};
          op_b <= op_b >> 1;
          if (count == '0) begin
            state <= FIX;
          end else begin
            count <= count - CW'(1);
          end
        end
        FIX: begin
          bus.product   <= fixed;
`ifdef SIGNED_MULT_OVF_EN
          bus.ovf       <= ~((&top_bits) | (~|top_bits));
`endif
          bus.out_valid <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
